uart_sha_block_loader: RTL and testbench
========================================

Name: uart_sha_block_loader

Overview:
Sequencer between the UART receiver and the SHA-256 core. It collects received bytes into 512-bit message blocks, MSB-first. It presents each complete block to the hash core over a valid/ready handshake. It discards stalled partial blocks after an inter-byte timeout, and it flags bytes that arrive while a block is still waiting for the core.

Parameters:
UART_DATA_WIDTH, 8, width of each received byte.
BYTES_PER_BLOCK, 64, bytes per message block; block width = BYTES_PER_BLOCK*UART_DATA_WIDTH = 512.
TIMEOUT_CLKS, 4160, idle clocks allowed between bytes of a partial block (104 clks/bit x 10 bits x 4 frames).
CNT_WIDTH, 16, width of the timeout counter and the block counter.

Ports:
i_Clock  input  1  system clock; all logic on the rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Rx_DV  input  1  one-cycle strobe: byte valid from the UART receiver.
i_Rx_Byte  input  UART_DATA_WIDTH  received byte; sampled only when i_Rx_DV=1.
o_Block_Valid  output  1  complete block available on o_Block.
i_Block_Ready  input  1  hash core accepts the block.
o_Block  output  512  assembled block; byte 0 sits in [511:504].
o_Block_Count  output  CNT_WIDTH  number of blocks handed off since reset; wraps.
o_Overrun  output  1  one-cycle pulse: a byte was dropped.
o_Timeout  output  1  one-cycle pulse: a partial block was discarded.

Behaviour:
- Reset (i_Reset=1 at a clock edge) forces the following, regardless of state or handshake in progress:
  - state=S_COLLECT; byte index=0; timeout counter=0.
  - o_Block=0, o_Block_Valid=0, o_Block_Count=0, o_Overrun=0, o_Timeout=0.
- o_Overrun and o_Timeout default to 0 every cycle unless set as described below.
- S_COLLECT:
  - On i_Rx_DV=1: o_Block <= {o_Block[503:0], i_Rx_Byte}; timeout counter <= 0.
  - If index < BYTES_PER_BLOCK-1, then index <= index+1.
  - Else index <= 0, state <= S_PRESENT, and o_Block_Valid <= 1. o_Block_Valid rises the cycle after the 64th strobe.
- Timeout (S_COLLECT only):
  - With index != 0 and i_Rx_DV=0, the counter increments each cycle.
  - When counter == TIMEOUT_CLKS-1: index <= 0, counter <= 0, o_Block <= 0, o_Timeout pulses for 1 cycle.
  - With index == 0 the counter is held at 0; an empty buffer never times out.
  - If i_Rx_DV=1 in the same cycle the counter would expire, the byte wins: it is accepted, the counter clears, and there is no timeout.
- S_PRESENT:
  - o_Block_Valid=1 and o_Block are held stable until handshake.
  - Handshake occurs when o_Block_Valid & i_Block_Ready in the same cycle. Next cycle: o_Block_Valid=0, state=S_COLLECT, index=0, o_Block_Count <= o_Block_Count+1 (mod 2^CNT_WIDTH).
  - o_Block is not cleared on handshake; it is overwritten by shifting.
  - i_Rx_DV=1 in S_PRESENT, including the handshake cycle: the byte is dropped, o_Overrun pulses the next cycle, and index and o_Block are unchanged.
  - The timeout counter is held at 0 in S_PRESENT.
- i_Block_Ready asserted while in S_COLLECT is ignored.
- Latency: 1 clock from the final byte strobe to o_Block_Valid; 1 clock from handshake to readiness for a new byte.
- Unused state encodings return to S_COLLECT with index=0.

Test Plan:
- Reset, then 64 strobes of bytes 0x00..0x3F with i_Block_Ready=0. Required: o_Block_Valid=1 one cycle after the 64th strobe, o_Block[511:504]=0x00, o_Block[7:0]=0x3F, o_Block_Count=0.
- From the previous state, hold o_Block_Valid 20 cycles, then assert i_Block_Ready for 1 cycle. Required: o_Block stable throughout; o_Block_Valid=0 and o_Block_Count=1 the next cycle.
- While o_Block_Valid=1, strobe byte 0xAA, then strobe 0x55 in the handshake cycle. Required: two o_Overrun pulses; o_Block unchanged; next block starts with index 0.
- Send 10 bytes, then idle. Required: o_Timeout pulses exactly TIMEOUT_CLKS cycles after the 10th strobe; a following 64 bytes of 0x11 yield o_Block = all 0x11.
- Send 5 bytes; strobe the 6th byte on exactly the expiry cycle. Required: no o_Timeout; byte accepted; index=6.
- Assert i_Reset mid-block (index=30) and again during S_PRESENT. Required: all outputs 0 next cycle; a full 64-byte block after release completes normally.

Source files
------------

// File: rtl/uart_sha_block_loader.sv
// Packs UART bytes MSB-first into 512-bit SHA-256 message blocks
// and hands each block to the hash core over valid/ready.
module uart_sha_block_loader #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int BYTES_PER_BLOCK = 64,
  parameter int TIMEOUT_CLKS    = 4160,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_DV,
  input  logic [UART_DATA_WIDTH-1:0] i_Rx_Byte,
  output logic                 o_Block_Valid,
  input  logic                 i_Block_Ready,
  output logic [BYTES_PER_BLOCK*UART_DATA_WIDTH-1:0] o_Block,
  output logic [CNT_WIDTH-1:0] o_Block_Count,
  output logic                 o_Overrun,
  output logic                 o_Timeout
);

  localparam int BW = BYTES_PER_BLOCK * UART_DATA_WIDTH;
  localparam int IW = $clog2(BYTES_PER_BLOCK);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_BLOCK - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_PRESENT = 2'd1
  } state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [CNT_WIDTH-1:0] tcnt, tcnt_nxt;
  logic [BW-1:0]        blk_nxt;
  logic                 valid_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 ovr_nxt;
  logic                 to_nxt;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= S_COLLECT;
      idx           <= '0;
      tcnt          <= '0;
      o_Block       <= '0;
      o_Block_Valid <= 1'b0;
      o_Block_Count <= '0;
      o_Overrun     <= 1'b0;
      o_Timeout     <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      tcnt          <= tcnt_nxt;
      o_Block       <= blk_nxt;
      o_Block_Valid <= valid_nxt;
      o_Block_Count <= count_nxt;
      o_Overrun     <= ovr_nxt;
      o_Timeout     <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tcnt_nxt  = tcnt;
    blk_nxt   = o_Block;
    valid_nxt = o_Block_Valid;
    count_nxt = o_Block_Count;
    ovr_nxt   = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      S_COLLECT: begin
        valid_nxt = 1'b0;
        if (i_Rx_DV) begin
          // a byte on the expiry cycle beats the timeout
          blk_nxt  = {o_Block[BW-UART_DATA_WIDTH-1:0], i_Rx_Byte};
          tcnt_nxt = '0;
          if (idx != LAST_IDX) begin
            idx_nxt = idx + IW'(1);
          end else begin
            idx_nxt   = '0;
            state_nxt = S_PRESENT;
            valid_nxt = 1'b1;
          end
        end else if (idx == '0) begin
          tcnt_nxt = '0;
        end else if (tcnt == TO_LAST) begin
          idx_nxt  = '0;
          tcnt_nxt = '0;
          blk_nxt  = '0;
          to_nxt   = 1'b1;
        end else begin
          tcnt_nxt = tcnt + CNT_WIDTH'(1);
        end
      end
      S_PRESENT: begin
        tcnt_nxt  = '0;
        valid_nxt = 1'b1;
        ovr_nxt   = i_Rx_DV;
        if (i_Block_Ready) begin
          valid_nxt = 1'b0;
          state_nxt = S_COLLECT;
          idx_nxt   = '0;
          count_nxt = o_Block_Count + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = S_COLLECT;
        idx_nxt   = '0;
        tcnt_nxt  = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_sha_block_loader.sv
// Scoreboard bench for uart_sha_block_loader: stimulus queues expected
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_sha_block_loader;

  localparam int TO = 4160;

  logic         clk = 1'b0;
  logic         rst;
  logic         dv;
  logic [7:0]   rx_byte;
  logic         valid;
  logic         ready;
  logic [511:0] blk;
  logic [15:0]  count;
  logic         ovr;
  logic         tmo;

  uart_sha_block_loader dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (dv),
    .i_Rx_Byte    (rx_byte),
    .o_Block_Valid(valid),
    .i_Block_Ready(ready),
    .o_Block      (blk),
    .o_Block_Count(count),
    .o_Overrun    (ovr),
    .o_Timeout    (tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] blk;
    logic [15:0]  cnt;
    int           cyc;
  } blk_exp_t;

  typedef struct {
    logic [15:0] cnt;
    int          cyc;
  } hs_exp_t;

  blk_exp_t blk_q[$];
  hs_exp_t  hs_q[$];
  int       to_q[$];
  int       ov_q[$];

  int errors = 0;
  int checks = 0;

  // monitor
  logic         pv = 1'b0;
  logic [511:0] pblk = '0;
  blk_exp_t     be;
  hs_exp_t      he;
  int           ce;

  always @(negedge clk) begin
    if (valid === 1'b1 && !pv) begin
      checks++;
      if (blk_q.size() == 0) begin
        errors++;
        $display("FAIL blk_unexpected: valid rose at cyc %0d, required no block", cyc);
      end else begin
        be = blk_q.pop_front();
        if (cyc != be.cyc || blk !== be.blk || count !== be.cnt) begin
          errors++;
          $display("FAIL blk: cyc %0d cnt %0d blk %0h, required cyc %0d cnt %0d blk %0h",
                   cyc, count, blk, be.cyc, be.cnt, be.blk);
        end
      end
    end
    if (valid === 1'b1 && pv) begin
      checks++;
      if (blk !== pblk) begin
        errors++;
        $display("FAIL blk_stable: cyc %0d got %0h required %0h", cyc, blk, pblk);
      end
    end
    if (valid === 1'b0 && pv) begin
      checks++;
      if (hs_q.size() == 0) begin
        errors++;
        $display("FAIL hs_unexpected: valid fell at cyc %0d, required held", cyc);
      end else begin
        he = hs_q.pop_front();
        if (cyc != he.cyc || count !== he.cnt) begin
          errors++;
          $display("FAIL hs: cyc %0d cnt %0d, required cyc %0d cnt %0d",
                   cyc, count, he.cyc, he.cnt);
        end
      end
    end
    if (tmo === 1'b1) begin
      checks++;
      if (to_q.size() == 0) begin
        errors++;
        $display("FAIL timeout_unexpected: pulse at cyc %0d, required none", cyc);
      end else begin
        ce = to_q.pop_front();
        if (cyc != ce) begin
          errors++;
          $display("FAIL timeout_cyc: got %0d required %0d", cyc, ce);
        end
      end
    end
    if (ovr === 1'b1) begin
      checks++;
      if (ov_q.size() == 0) begin
        errors++;
        $display("FAIL overrun_unexpected: pulse at cyc %0d, required none", cyc);
      end else begin
        ce = ov_q.pop_front();
        if (cyc != ce) begin
          errors++;
          $display("FAIL overrun_cyc: got %0d required %0d", cyc, ce);
        end
      end
    end
    pv   = (valid === 1'b1);
    pblk = blk;
  end

  function automatic logic [511:0] ramp(input int base, input int step);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[511-8*i -: 8] = 8'(base + step * i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b, output int e);
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    e  = cyc;
    dv = 1'b0;
  endtask

  task automatic send(input int base, input int step, input int first,
                      input int n, output int e);
    for (int i = first; i < first + n; i++) strobe(8'(base + step * i), e);
  endtask

  task automatic expect_blk(input logic [511:0] b, input logic [15:0] c,
                            input int e);
    blk_exp_t x;
    x.blk = b;
    x.cnt = c;
    x.cyc = e;
    blk_q.push_back(x);
  endtask

  task automatic expect_hs(input logic [15:0] c, input int e);
    hs_exp_t x;
    x.cnt = c;
    x.cyc = e;
    hs_q.push_back(x);
  endtask

  task automatic handshake(input logic [15:0] c);
    int e;
    ready = 1'b1;
    @(posedge clk);
    #1;
    e     = cyc;
    ready = 1'b0;
    expect_hs(c, e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 512'(valid), '0);
    chk({tag, "_blk"},   blk,         '0);
    chk({tag, "_count"}, 512'(count), '0);
    chk({tag, "_ovr"},   512'(ovr),   '0);
    chk({tag, "_tmo"},   512'(tmo),   '0);
  endtask

  initial begin
    int e;
    int e5;
    rst = 1'b1;
    dv = 1'b0;
    ready = 1'b0;
    rx_byte = '0;
    idle(2);
    chk_zero("reset");
    rst = 1'b0;

    // block of 0x00..0x3F, core not ready
    send(0, 1, 0, 64, e);
    expect_blk(ramp(0, 1), 16'd0, e);
    idle(20);
    handshake(16'd1);
    idle(2);

    // overruns while presenting, one in the handshake cycle
    send(8'hFF, -1, 0, 64, e);
    expect_blk(ramp(8'hFF, -1), 16'd1, e);
    idle(2);
    strobe(8'hAA, e);
    ov_q.push_back(e);
    idle(1);
    ready = 1'b1;
    strobe(8'h55, e);
    ready = 1'b0;
    ov_q.push_back(e);
    expect_hs(16'd2, e);
    idle(1);
    chk("blk_kept", blk, ramp(8'hFF, -1));

    // timeout after 10 bytes; ready in collect is ignored
    ready = 1'b1;
    send(8'h20, 1, 0, 10, e);
    ready = 1'b0;
    to_q.push_back(e + TO);
    idle(TO + 5);
    chk("blk_cleared", blk, '0);
    send(8'h11, 0, 0, 64, e);
    expect_blk({64{8'h11}}, 16'd2, e);
    idle(3);
    handshake(16'd3);

    // 6th byte lands exactly on the expiry cycle
    send(0, 1, 0, 5, e5);
    idle(TO - 1);
    strobe(8'h05, e);
    send(0, 1, 6, 58, e);
    expect_blk(ramp(0, 1), 16'd3, e);
    idle(2);
    handshake(16'd4);
    idle(2);

    // reset mid-block and during present
    send(8'h40, 1, 0, 30, e);
    rst = 1'b1;
    idle(1);
    chk_zero("rst_mid");
    rst = 1'b0;
    send(8'h80, 1, 0, 64, e);
    expect_blk(ramp(8'h80, 1), 16'd0, e);
    idle(3);
    rst = 1'b1;
    idle(1);
    expect_hs(16'd0, cyc);
    chk_zero("rst_present");
    rst = 1'b0;
    send(8'h80, 1, 0, 64, e);
    expect_blk(ramp(8'h80, 1), 16'd0, e);
    idle(2);
    handshake(16'd1);
    idle(3);

    checks++;
    if (blk_q.size() != 0) begin
      errors++;
      $display("FAIL blk_missing: got %0d pending required 0", blk_q.size());
    end
    checks++;
    if (hs_q.size() != 0) begin
      errors++;
      $display("FAIL hs_missing: got %0d pending required 0", hs_q.size());
    end
    checks++;
    if (to_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_missing: got %0d pending required 0", to_q.size());
    end
    checks++;
    if (ov_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_missing: got %0d pending required 0", ov_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
